// File: rtl/eq_mix_pkg.sv
// Shared constants and types for the equaliser band mixer.
//   N_BANDS     number of filter-bank bands summed (0 = lowpass ... 9 = highpass)
//   DATA_W      signed band sample / output width
//   GAIN_W      signed Q2.10 gain width, GAIN_FRAC fractional bits
//   ACC_W       accumulator width, wide enough for N_BANDS full-precision products
//   UNITY_GAIN  1.0 in Q2.10
//   state_e     mixer sequencing states
package eq_mix_pkg;

  localparam int unsigned N_BANDS   = 10;
  localparam int unsigned DATA_W    = 24;
  localparam int unsigned GAIN_W    = 12;
  localparam int unsigned GAIN_FRAC = 10;
  localparam int unsigned ACC_W     = DATA_W + GAIN_W + $clog2(N_BANDS);
  localparam int unsigned PROD_W    = DATA_W + GAIN_W;
  localparam int unsigned IDX_W     = 4;

  localparam logic signed [GAIN_W-1:0] UNITY_GAIN = 12'sd1024;
  localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(N_BANDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } state_e;

endpackage

// File: rtl/eq_round_sat.sv
// Combinational round-half-up and saturate from accumulator to output width.
//   acc       signed accumulator, GAIN_FRAC fractional bits
//   sample    signed DATA_W result, clamped to the representable range
//   sat_flag  high when clamping took place
module eq_round_sat
  import eq_mix_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] sample,
  output logic                     sat_flag
);

  localparam logic signed [DATA_W-1:0] OutMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OutMin = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  SatMax = {{(ACC_W-DATA_W){1'b0}}, OutMax};
  localparam logic signed [ACC_W-1:0]  SatMin = {{(ACC_W-DATA_W){1'b1}}, OutMin};
  localparam logic signed [ACC_W-1:0]  RoundBias = ACC_W'(2 ** (GAIN_FRAC - 1));

  logic signed [ACC_W-1:0] rounded;

  always_comb begin
    // Bias by half an LSB then floor: ties round toward +inf.
    rounded  = (acc + RoundBias) >>> GAIN_FRAC;
    sample   = rounded[DATA_W-1:0];
    sat_flag = 1'b0;
    if (rounded > SatMax) begin
      sample   = OutMax;
      sat_flag = 1'b1;
    end else if (rounded < SatMin) begin
      sample   = OutMin;
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Per-band gain and sum of the filter-bank outputs through one shared MAC.
// A sample set is snapshotted on acceptance, then one band per clock is multiplied by
// its active gain and accumulated; the sum is rounded, saturated and presented once.
//   clk, rst_n     clock, synchronous active-low reset
//   bands_in       packed band samples, band k at [k*DATA_W +: DATA_W]
//   sample_valid   strobe: bands_in holds a new sample set
//   gain_wr_*      shadow gain write port (addresses >= N_BANDS ignored)
//   audio_out      equalised sample, held until the next result
//   out_valid      one-cycle pulse per new audio_out
//   busy           high while a sample is in flight
//   overrun        sticky: a sample_valid arrived while busy and was dropped
// Optional: define EQ_MIX_CLIP_CNT_EN to add clip_count, a saturating count of
// results that were clamped.
module eq_band_mixer
  import eq_mix_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BANDS*DATA_W-1:0]  bands_in,
  input  logic                       sample_valid,
  input  logic                       gain_wr_en,
  input  logic [IDX_W-1:0]           gain_wr_addr,
  input  logic signed [GAIN_W-1:0]   gain_wr_data,
  output logic signed [DATA_W-1:0]   audio_out,
  output logic                       out_valid,
  output logic                       busy,
`ifdef EQ_MIX_CLIP_CNT_EN
  output logic [15:0]                clip_count,
`endif
  output logic                       overrun
);

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]  snap_q     [N_BANDS];
  logic signed [GAIN_W-1:0]  gain_shd_q [N_BANDS];
  logic signed [GAIN_W-1:0]  gain_act_q [N_BANDS];

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [DATA_W-1:0]  rs_sample;
  logic                      rs_sat;

  assign prod     = snap_q[idx_q] * gain_act_q[idx_q];
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  eq_round_sat u_round_sat (
    .acc      (acc_q),
    .sample   (rs_sample),
    .sat_flag (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_q     <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef EQ_MIX_CLIP_CNT_EN
      clip_count <= '0;
`endif
      for (int k = 0; k < N_BANDS; k++) begin
        snap_q[k]     <= '0;
        gain_shd_q[k] <= UNITY_GAIN;
        gain_act_q[k] <= UNITY_GAIN;
      end
    end else begin
      out_valid <= 1'b0;

      for (int k = 0; k < N_BANDS; k++) begin
        if (gain_wr_en && gain_wr_addr == IDX_W'(k)) begin
          gain_shd_q[k] <= gain_wr_data;
        end
      end

      if (sample_valid && state_q != StIdle) begin
        overrun <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (sample_valid) begin
            for (int k = 0; k < N_BANDS; k++) begin
              snap_q[k] <= bands_in[k*DATA_W +: DATA_W];
              // A write on the accepting edge goes straight into the active bank.
              gain_act_q[k] <= (gain_wr_en && gain_wr_addr == IDX_W'(k)) ? gain_wr_data
                                                                        : gain_shd_q[k];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StAcc;
          end
        end
        StAcc: begin
          acc_q <= acc_q + prod_ext;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          audio_out <= rs_sample;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
`ifdef EQ_MIX_CLIP_CNT_EN
          if (rs_sat && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
module tb_eq_band_mixer;

  localparam int NB = 10;
  localparam int DW = 24;

  typedef int band_arr_t [NB];
  typedef struct {
    int     gain;
    int     band;
    longint expv;
    bit     sat;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NB*DW-1:0]       bands_in;
  logic                   sample_valid;
  logic                   gain_wr_en;
  logic [3:0]             gain_wr_addr;
  logic signed [11:0]     gain_wr_data;
  logic signed [DW-1:0]   audio_out;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;
`ifdef EQ_MIX_CLIP_CNT_EN
  logic [15:0]            clip_count;
`endif

  eq_band_mixer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bands_in     (bands_in),
    .sample_valid (sample_valid),
    .gain_wr_en   (gain_wr_en),
    .gain_wr_addr (gain_wr_addr),
    .gain_wr_data (gain_wr_data),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy),
`ifdef EQ_MIX_CLIP_CNT_EN
    .clip_count   (clip_count),
`endif
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     sh_gain [NB];
  int     act_gain [NB];
  longint exp_val;
  bit     exp_sat;
  int     clip_exp = 0;
  vec_t   tbl [8];

  // Reference: plain integer sum of products, round half up, clamp.
  function automatic longint model_mix(input band_arr_t b, input band_arr_t g,
                                       output bit sat);
    longint acc = 0;
    longint r;
    for (int k = 0; k < NB; k++) acc += longint'(b[k]) * longint'(g[k]);
    r = (acc + 512) >>> 10;
    sat = 1'b0;
    if (r > 64'sd8388607) begin
      r = 8388607;
      sat = 1'b1;
    end else if (r < -64'sd8388608) begin
      r = -8388608;
      sat = 1'b1;
    end
    return r;
  endfunction

  function automatic band_arr_t fill(input int v);
    band_arr_t b;
    for (int k = 0; k < NB; k++) b[k] = v;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_bands(input band_arr_t b);
    int v;
    for (int k = 0; k < NB; k++) begin
      v = b[k];
      bands_in[k*DW +: DW] = v[DW-1:0];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    gain_wr_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) sh_gain[k] = 1024;
    clip_exp = 0;
  endtask

  task automatic write_gain(input int addr, input int data);
    gain_wr_en = 1'b1;
    gain_wr_addr = addr[3:0];
    gain_wr_data = data[11:0];
    if (addr < NB) sh_gain[addr] = data;
    tick();
    gain_wr_en = 1'b0;
  endtask

  task automatic accept(input band_arr_t b, input bit wr, input int waddr, input int wdata,
                        output int t0);
    set_bands(b);
    sample_valid = 1'b1;
    if (wr) begin
      gain_wr_en = 1'b1;
      gain_wr_addr = waddr[3:0];
      gain_wr_data = wdata[11:0];
      if (waddr < NB) sh_gain[waddr] = wdata;
    end
    for (int k = 0; k < NB; k++) act_gain[k] = sh_gain[k];
    exp_val = model_mix(b, act_gain, exp_sat);
    tick();
    sample_valid = 1'b0;
    gain_wr_en = 1'b0;
    t0 = cyc;
    check("busy_after_accept", longint'(busy), 1);
  endtask

  // Accepting edge counts as edge 1; the result must appear after edge 12.
  task automatic wait_out(input string name, input int t0, input longint expv, input bit sat);
    while (!out_valid && (cyc - t0) < 20) tick();
    check({name, "_latency"}, longint'(cyc - t0 + 1), 12);
    check(name, longint'(audio_out), expv);
    if (sat) clip_exp++;
    tick();
    check({name, "_pulse_width"}, longint'(out_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int t0;
    int pulses;
    band_arr_t b;

    tbl[0] = '{gain: 1024,  band: 1000,     expv: 10000,    sat: 1'b0};
    tbl[1] = '{gain: 2047,  band: 8388607,  expv: 8388607,  sat: 1'b1};
    tbl[2] = '{gain: 2047,  band: -8388608, expv: -8388608, sat: 1'b1};
    tbl[3] = '{gain: -2048, band: 1000,     expv: -20000,   sat: 1'b0};
    tbl[4] = '{gain: 52,    band: 1,        expv: 1,        sat: 1'b0};
    tbl[5] = '{gain: -52,   band: 1,        expv: -1,       sat: 1'b0};
    tbl[6] = '{gain: -51,   band: 1,        expv: 0,        sat: 1'b0};
    tbl[7] = '{gain: 51,    band: 1,        expv: 0,        sat: 1'b0};

    bands_in = '0;
    gain_wr_addr = '0;
    gain_wr_data = '0;
    do_reset();

    check("reset_audio_out", longint'(audio_out), 0);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_overrun", longint'(overrun), 0);

    // Uniform-gain vectors; row 0 relies on the reset unity gains.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) for (int k = 0; k < NB; k++) write_gain(k, tbl[i].gain);
      accept(fill(tbl[i].band), 1'b0, 0, 0, t0);
      wait_out($sformatf("vec%0d", i), t0, tbl[i].expv, tbl[i].sat);
    end
`ifdef EQ_MIX_CLIP_CNT_EN
    check("clip_count_table", longint'(clip_count), 2);
`endif

    // Single active band, negative gain and sign.
    for (int k = 0; k < NB; k++) write_gain(k, 0);
    write_gain(3, -2048);
    b = fill(7777);
    b[3] = -5000;
    accept(b, 1'b0, 0, 0, t0);
    wait_out("band3_neg_gain", t0, 10000, 1'b0);
    write_gain(3, 512);
    b[3] = 1;
    accept(b, 1'b0, 0, 0, t0);
    wait_out("round_half_up_pos", t0, 1, 1'b0);
    write_gain(3, -512);
    accept(b, 1'b0, 0, 0, t0);
    wait_out("round_half_up_neg", t0, 0, 1'b0);
    write_gain(3, 1536);
    accept(b, 1'b0, 0, 0, t0);
    wait_out("round_1p5", t0, 2, 1'b0);

    // Gain write on the accepting edge must reach the active bank.
    accept(fill(50), 1'b1, 5, 1024, t0);
    wait_out("write_through", t0, 125, 1'b0);

    // Second strobe while busy is dropped and latches overrun.
    do_reset();
    accept(fill(1000), 1'b0, 0, 0, t0);
    tick();
    tick();
    set_bands(fill(3));
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("overrun_set", longint'(overrun), 1);
    wait_out("overrun_first_result", t0, 10000, 1'b0);
    pulses = 0;
    repeat (14) begin
      tick();
      if (out_valid) pulses++;
    end
    check("overrun_no_second_result", longint'(pulses), 0);
    accept(fill(2), 1'b0, 0, 0, t0);
    wait_out("after_overrun", t0, 20, 1'b0);
    check("overrun_sticky", longint'(overrun), 1);

    // Gain change while busy affects only the next sample.
    do_reset();
    check("overrun_cleared", longint'(overrun), 0);
    accept(fill(100), 1'b0, 0, 0, t0);
    tick();
    tick();
    tick();
    write_gain(0, 0);
    wait_out("shadow_not_active", t0, 1000, 1'b0);
    accept(fill(100), 1'b0, 0, 0, t0);
    wait_out("shadow_next_sample", t0, 900, 1'b0);

    // Reset mid-accumulation abandons the sample and restores unity gains.
    write_gain(2, 0);
    accept(fill(7), 1'b0, 0, 0, t0);
    tick();
    tick();
    tick();
    set_bands(fill(9));
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) sh_gain[k] = 1024;
    clip_exp = 0;
    check("midacc_reset_busy", longint'(busy), 0);
    check("midacc_reset_overrun", longint'(overrun), 0);
    pulses = 0;
    repeat (15) begin
      tick();
      if (out_valid) pulses++;
    end
    check("midacc_reset_no_result", longint'(pulses), 0);
    for (int a = NB; a < 16; a++) write_gain(a, 0);
    accept(fill(1), 1'b0, 0, 0, t0);
    wait_out("unity_after_reset", t0, 10, 1'b0);

    // Randomised gains and samples against the reference model.
    for (int it = 0; it < 40; it++) begin
      int nw;
      int mode;
      nw = int'($urandom_range(0, 4));
      repeat (nw) write_gain(int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)) - 2048);
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < NB; k++) begin
        case (mode)
          0: b[k] = int'($urandom_range(0, 16777215)) - 8388608;
          1: b[k] = int'($urandom_range(0, 4000)) - 2000;
          default: b[k] = ($urandom_range(0, 1) != 0) ? 8388607 : -8388608;
        endcase
      end
      accept(b, 1'b0, 0, 0, t0);
      wait_out($sformatf("rand%0d", it), t0, exp_val, exp_sat);
    end
`ifdef EQ_MIX_CLIP_CNT_EN
    check("clip_count_random", longint'(clip_count), longint'(clip_exp));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
